// File: rtl/gpio_input_conditioner.sv
// rtl/gpio_input_conditioner.sv - per-channel GPIO synchroniser, debouncer, edge detect and sticky irq flags
module gpio_input_conditioner #(
  parameter int GPIO_WIDTH      = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [GPIO_WIDTH-1:0] gpio_input,
  input  logic [GPIO_WIDTH-1:0] rise_enable,
  input  logic [GPIO_WIDTH-1:0] fall_enable,
  input  logic [GPIO_WIDTH-1:0] pending_clear,
  output logic [GPIO_WIDTH-1:0] gpio_stable,
  output logic [GPIO_WIDTH-1:0] rise_pulse,
  output logic [GPIO_WIDTH-1:0] fall_pulse,
  output logic [GPIO_WIDTH-1:0] irq_pending,
  output logic                  irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [GPIO_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [CW-1:0]         count  [GPIO_WIDTH];
  logic [GPIO_WIDTH-1:0] sync;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= gpio_input;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Any sample agreeing with the accepted level restarts the count; the
  // pulses are produced on the same edge that updates gpio_stable.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < GPIO_WIDTH; i++) count[i] <= '0;
      gpio_stable <= '0;
      rise_pulse  <= '0;
      fall_pulse  <= '0;
    end else begin
      for (int i = 0; i < GPIO_WIDTH; i++) begin
        rise_pulse[i] <= 1'b0;
        fall_pulse[i] <= 1'b0;
        if (sync[i] == gpio_stable[i]) begin
          count[i] <= '0;
        end else if (count[i] == LAST) begin
          count[i]       <= '0;
          gpio_stable[i] <= sync[i];
          rise_pulse[i]  <= sync[i];
          fall_pulse[i]  <= ~sync[i];
        end else begin
          count[i] <= count[i] + CW'(1);
        end
      end
    end
  end

  // Set has priority over a same-cycle clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      irq_pending <= '0;
    end else begin
      irq_pending <= (irq_pending & ~pending_clear)
                   | (rise_pulse & rise_enable)
                   | (fall_pulse & fall_enable);
    end
  end

  assign irq = |irq_pending;

endmodule

// File: doc/gpio_input_conditioner.md
Name: gpio_input_conditioner

Overview:
Parametrised per-channel GPIO input front end for the rvx GPIO path. It replaces the single-flop button sampling used on board tops with three stages per channel: an N-stage synchroniser, a counter-based debouncer, and edge detection with sticky, maskable interrupt-pending flags. It sits between the pad-side input vector and the GPIO register block. It drives a clean level, one-cycle edge pulses, and a combined interrupt line.

Parameters:
GPIO_WIDTH, 8, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flop depth per channel (>=2)
DEBOUNCE_CYCLES, 120000, consecutive agreeing synchronised samples required to accept a new level (>=1)

Ports:
clock  input  1  system clock; the only clock
reset  input  1  asynchronous, active-low reset
gpio_input  input  GPIO_WIDTH  raw asynchronous pad inputs
rise_enable  input  GPIO_WIDTH  per-channel: a debounced rising edge sets pending
fall_enable  input  GPIO_WIDTH  per-channel: a debounced falling edge sets pending
pending_clear  input  GPIO_WIDTH  per-channel, one-cycle write-1-to-clear of pending
gpio_stable  output  GPIO_WIDTH  debounced level
rise_pulse  output  GPIO_WIDTH  one-cycle pulse on an accepted 0->1
fall_pulse  output  GPIO_WIDTH  one-cycle pulse on an accepted 1->0
irq_pending  output  GPIO_WIDTH  sticky per-channel pending flags
irq  output  1  OR-reduction of irq_pending

Behaviour:
- Reset: the single reset input is asynchronous and active-low. While reset is low, all synchroniser flops, counters, gpio_stable, rise_pulse, fall_pulse and irq_pending are 0, and irq is 0. These take effect immediately, with no clock edge needed. Reset release is used directly; no internal reset synchroniser is included.
- Synchroniser: a chain of SYNC_STAGES flops per channel. sync[i] is the last stage.
- Counter: width is $clog2(DEBOUNCE_CYCLES+1) per channel.
- Counter update, per channel, each clock:
  - If sync == gpio_stable: count <= 0.
  - Else if count == DEBOUNCE_CYCLES-1: gpio_stable <= sync and count <= 0.
  - Else: count <= count+1.
- Acceptance rule: gpio_stable changes only after sync has differed from it on DEBOUNCE_CYCLES consecutive clock edges. Any single agreeing sample restarts the count. The counter never wraps.
- DEBOUNCE_CYCLES=1: gpio_stable follows sync with one cycle of delay.
- Latency: a clean step at gpio_input, sampled at edge 0, appears on gpio_stable after edge SYNC_STAGES+DEBOUNCE_CYCLES-1. That is SYNC_STAGES+DEBOUNCE_CYCLES cycles total.
- Edge pulses: rise_pulse[i]/fall_pulse[i] are registered. Each is high for exactly the one cycle in which gpio_stable[i] first shows its new value. Rise and fall can never be high together on one channel. Back-to-back pulses are separated by at least DEBOUNCE_CYCLES cycles.
- Pending flags:
  - Set when (rise_pulse & rise_enable) | (fall_pulse & fall_enable), using the enables in the same cycle as the pulse.
  - Cleared when pending_clear is high.
  - If set and clear occur in the same cycle, set wins.
  - Changing an enable does not affect an already-set flag.
- irq is combinational OR of irq_pending. It is high in the same cycle as the first set flag.
- Power-up rule: gpio_stable resets to 0. An input held high through reset produces one rise_pulse after the normal latency, and sets pending if rise_enable is asserted. Software masks enables until initialised.
- Reset mid-debounce: the partial count is discarded. The acceptance restarts from 0 after reset release.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.

Test Plan:
(GPIO_WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=8 unless stated.)
1. Release reset with inputs 0, then step gpio_input[0] 0->1 at edge 0 -> gpio_stable[0]=1 from edge 9 (10 cycles). rise_pulse[0] is high for exactly that one cycle. Other channels stay 0.
2. Glitch: gpio_input[1] high for 7 cycles, then low -> no change on gpio_stable[1] and no pulses. Then high for 8 cycles -> accepted, one rise_pulse[1].
3. Bounce: gpio_input[2] toggles every 3 cycles for 30 cycles, then holds 1 -> exactly one rise_pulse[2], 10 cycles after the final toggle. Then release to 0 -> one fall_pulse[2].
4. Interrupts: rise_enable=4'b0010, fall_enable=0. Channel 1 rises then falls -> irq_pending=4'b0010 and irq=1 after the rise only. Pulse pending_clear[1] -> 0 next cycle. Assert pending_clear[1] in the same cycle as a new enabled rise_pulse[1] -> pending stays 1.
5. Async reset: assert reset low mid-count (count=5) with pending=4'b0011 -> all outputs 0 immediately, before any clock edge. After release, a held-high input needs the full 10 cycles again.
6. Multi-channel: channels 0 and 3 step high on the same edge, channel 1 falls from a stable 1 -> rise_pulse=4'b1001 and fall_pulse=4'b0010 in the same cycle. irq_pending reflects only the enabled channels.
